// File: rtl/uart_frame_loader.sv
// uart_frame_loader
//   Bridges uart_rx to the frame BRAM write port. Waits for a two-byte sync
//   header (or, with USE_SYNC=0, treats the first byte as pixel data), packs
//   BYTES_PER_PIXEL bytes per pixel word with the first byte in the MSBs, and
//   writes FRAME_PIXELS words to consecutive addresses starting at 0. A UART
//   framing error or an inter-byte timeout aborts the frame and re-arms the
//   header search.
//
// Ports
//   clk            in   system clock
//   rst            in   synchronous reset, active-high
//   rx_data        in   [7:0] received byte
//   rx_valid       in   one-cycle strobe qualifying rx_data
//   rx_frame_error in   stop-bit error, qualified by rx_valid
//   wr_en          out  BRAM write strobe, one cycle per pixel
//   wr_addr        out  [ADDR_W-1:0] BRAM write address
//   wr_data        out  [8*BYTES_PER_PIXEL-1:0] packed pixel word
//   frame_done     out  pulse coincident with the last pixel's wr_en
//   busy           out  high while a frame is being received
//   frame_count    out  [7:0] completed frames, wraps
//   err_count      out  [7:0] aborts plus framing errors, saturates at 255
module uart_frame_loader #(
    parameter int         ADDR_W          = 19,
    parameter int         FRAME_PIXELS    = 307200,
    parameter int         BYTES_PER_PIXEL = 1,
    parameter int         USE_SYNC        = 1,
    parameter logic [7:0] SYNC0           = 8'hAA,
    parameter logic [7:0] SYNC1           = 8'h55,
    parameter int         TIMEOUT_CYC     = 5_000_000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_valid,
    input  logic                         rx_frame_error,
    output logic                         wr_en,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic [8*BYTES_PER_PIXEL-1:0] wr_data,
    output logic                         frame_done,
    output logic                         busy,
    output logic [7:0]                   frame_count,
    output logic [7:0]                   err_count
);

    localparam int                PIX_W     = 8 * BYTES_PER_PIXEL;
    localparam int                TMO_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);
    localparam logic [1:0]        LAST_IDX  = 2'(BYTES_PER_PIXEL - 1);
    localparam logic [TMO_W-1:0]  TMO_LIMIT = TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {S_SYNC0, S_SYNC1, S_RECV} state_t;

    state_t            state;
    logic [1:0]        byte_idx;
    logic [PIX_W-1:0]  shreg;
    logic [TMO_W-1:0]  tmo_cnt;

    logic [ADDR_W-1:0] pix_addr;
    logic [PIX_W-1:0]  packed_word;
    logic              take_byte;
    logic              timeout_hit;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Address the next completed pixel will use. wr_addr is bumped the cycle
    // after each write and cleared the cycle after frame_done, so this is
    // also the value wr_addr takes by default every cycle.
    assign pix_addr = frame_done ? '0 : (wr_en ? wr_addr + 1'b1 : wr_addr);

    // Shift register contents including the incoming byte; older bytes
    // migrate toward the MSBs.
    assign packed_word = (shreg << 8) | PIX_W'(rx_data);

    assign take_byte = rx_valid && !rx_frame_error &&
                       (state == S_RECV || (USE_SYNC == 0 && state == S_SYNC0));

    // A byte arriving in the limit cycle wins over the timeout.
    assign timeout_hit = (state == S_RECV) && !rx_valid && (tmo_cnt == TMO_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_SYNC0;
            byte_idx    <= '0;
            shreg       <= '0;
            tmo_cnt     <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
            frame_count <= '0;
            err_count   <= '0;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            wr_addr    <= pix_addr;

            if (frame_done)
                frame_count <= frame_count + 8'd1;

            if (state == S_RECV && !rx_valid)
                tmo_cnt <= tmo_cnt + 1'b1;
            else
                tmo_cnt <= '0;

            if (rx_valid && rx_frame_error) begin
                // Corrupt byte is dropped; any partial frame is abandoned.
                err_count <= sat_inc(err_count);
                if (state != S_SYNC0) begin
                    state    <= S_SYNC0;
                    busy     <= 1'b0;
                    byte_idx <= '0;
                    wr_addr  <= '0;
                end
            end else if (timeout_hit) begin
                err_count <= sat_inc(err_count);
                state     <= S_SYNC0;
                busy      <= 1'b0;
                byte_idx  <= '0;
                wr_addr   <= '0;
            end else if (rx_valid) begin
                case (state)
                    S_SYNC0: begin
                        if (USE_SYNC != 0 && rx_data == SYNC0)
                            state <= S_SYNC1;
                    end
                    S_SYNC1: begin
                        if (rx_data == SYNC1) begin
                            state    <= S_RECV;
                            busy     <= 1'b1;
                            wr_addr  <= '0;
                            byte_idx <= '0;
                        end else if (rx_data != SYNC0) begin
                            state <= S_SYNC0;
                        end
                    end
                    default: ;
                endcase

                if (take_byte) begin
                    if (byte_idx == LAST_IDX) begin
                        wr_en    <= 1'b1;
                        wr_data  <= packed_word;
                        byte_idx <= '0;
                        // Leave S_RECV together with the last write so a
                        // header byte arriving right behind it is not lost.
                        if (pix_addr == LAST_ADDR) begin
                            frame_done <= 1'b1;
                            state      <= S_SYNC0;
                            busy       <= 1'b0;
                        end else begin
                            state <= S_RECV;
                            busy  <= 1'b1;
                        end
                    end else begin
                        shreg    <= packed_word;
                        byte_idx <= byte_idx + 2'd1;
                        state    <= S_RECV;
                        busy     <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_loader.sv
// Testbench for uart_frame_loader. Two instances share one byte stream:
//   dut_a: 1 byte/pixel, 4-pixel frames, 100-cycle timeout
//   dut_b: 2 bytes/pixel, 2-pixel frames
// Expected writes are queued per instance with the cycle they must appear in;
// a negedge monitor pops and compares every wr_en.
module tb_uart_frame_loader;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
        logic        done;
        logic [31:0] cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_frame_error = 1'b0;
    int         sel = 0;

    logic       rx_valid_a, rx_valid_b;
    assign rx_valid_a = rx_valid && (sel == 0);
    assign rx_valid_b = rx_valid && (sel == 1);

    logic       wr_en_a, frame_done_a, busy_a;
    logic [7:0] wr_addr_a, wr_data_a, frame_count_a, err_count_a;
    logic       wr_en_b, frame_done_b, busy_b;
    logic [7:0] wr_addr_b, frame_count_b, err_count_b;
    logic [15:0] wr_data_b;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t qa[$];
    exp_t qb[$];

    uart_frame_loader #(.ADDR_W(8), .FRAME_PIXELS(4), .BYTES_PER_PIXEL(1),
                        .USE_SYNC(1), .SYNC0(8'hAA), .SYNC1(8'h55),
                        .TIMEOUT_CYC(100)) dut_a (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid_a),
        .rx_frame_error(rx_frame_error), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
        .wr_data(wr_data_a), .frame_done(frame_done_a), .busy(busy_a),
        .frame_count(frame_count_a), .err_count(err_count_a));

    uart_frame_loader #(.ADDR_W(8), .FRAME_PIXELS(2), .BYTES_PER_PIXEL(2),
                        .USE_SYNC(1), .SYNC0(8'hAA), .SYNC1(8'h55),
                        .TIMEOUT_CYC(100)) dut_b (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid_b),
        .rx_frame_error(rx_frame_error), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
        .wr_data(wr_data_b), .frame_done(frame_done_b), .busy(busy_b),
        .frame_count(frame_count_b), .err_count(err_count_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Monitors: one comparison per write, including the arrival cycle.
    always @(negedge clk) begin
        exp_t e;
        if (wr_en_a) begin
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL a_unexpected_write got addr %h data %h", wr_addr_a, wr_data_a);
            end else begin
                e = qa.pop_front();
                if (wr_addr_a !== e.addr || {8'h00, wr_data_a} !== e.data ||
                    frame_done_a !== e.done || cyc !== e.cyc) begin
                    errors++;
                    $display("FAIL a_write got addr %h data %h done %b cyc %0d want addr %h data %h done %b cyc %0d",
                             wr_addr_a, wr_data_a, frame_done_a, cyc, e.addr, e.data, e.done, e.cyc);
                end
            end
        end else if (frame_done_a) begin
            checks++; errors++;
            $display("FAIL a_done_without_write got 1 want 0");
        end
        if (wr_en_b) begin
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL b_unexpected_write got addr %h data %h", wr_addr_b, wr_data_b);
            end else begin
                e = qb.pop_front();
                if (wr_addr_b !== e.addr || wr_data_b !== e.data ||
                    frame_done_b !== e.done || cyc !== e.cyc) begin
                    errors++;
                    $display("FAIL b_write got addr %h data %h done %b cyc %0d want addr %h data %h done %b cyc %0d",
                             wr_addr_b, wr_data_b, frame_done_b, cyc, e.addr, e.data, e.done, e.cyc);
                end
            end
        end else if (frame_done_b) begin
            checks++; errors++;
            $display("FAIL b_done_without_write got 1 want 0");
        end
    end

    // Present a byte for exactly one clock; called at a negedge, returns at the next.
    task automatic by(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1; rx_frame_error = 1'b0;
        @(negedge clk);
    endtask

    task automatic fe(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1; rx_frame_error = 1'b1;
        @(negedge clk);
    endtask

    // Byte that completes a pixel: the write must show up one cycle later.
    task automatic px(input logic [7:0] b, input logic [7:0] addr,
                      input logic [15:0] data, input logic done);
        exp_t e;
        e.addr = addr; e.data = data; e.done = done; e.cyc = cyc + 1;
        if (sel == 0) qa.push_back(e); else qb.push_back(e);
        by(b);
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0; rx_frame_error = 1'b0;
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_a_outs"}, {wr_en_a, wr_addr_a, wr_data_a, frame_done_a, busy_a, frame_count_a, err_count_a}, 32'h0);
        chk({tag, "_b_outs"}, {wr_en_b, wr_addr_b, wr_data_b, frame_done_b, busy_b}, 32'h0);
        chk({tag, "_b_cnts"}, {frame_count_b, err_count_b}, 32'h0);
    endtask

    initial begin
        idle(3);
        chk_reset_state("reset");
        rst = 1'b0;
        idle(2);

        // Basic 1-byte pixels, frame of four.
        sel = 0;
        by(8'hAA); by(8'h55);
        chk("t1_busy_after_hdr", busy_a, 1);
        px(8'h10, 0, 16'h0010, 0); px(8'h20, 1, 16'h0020, 0);
        px(8'h30, 2, 16'h0030, 0); px(8'h40, 3, 16'h0040, 1);
        idle(3);
        chk("t1_frame_count", frame_count_a, 1);
        chk("t1_idle", {busy_a, wr_addr_a, err_count_a}, 0);

        // Two bytes per pixel, MSB first, back-to-back.
        sel = 1;
        by(8'hAA); by(8'h55);
        by(8'h12); px(8'h34, 0, 16'h1234, 0);
        by(8'h56); px(8'h78, 1, 16'h5678, 1);
        idle(3);
        chk("t2_frame_count", frame_count_b, 1);
        chk("t2_busy", busy_b, 0);

        // Header search: leading junk, repeated SYNC0.
        sel = 0;
        by(8'h00); by(8'hAA); by(8'hAA);
        chk("t3_busy_before_55", busy_a, 0);
        by(8'h55);
        chk("t3_busy_after_55", busy_a, 1);
        px(8'h77, 0, 16'h0077, 0); px(8'h78, 1, 16'h0078, 0);
        px(8'h79, 2, 16'h0079, 0); px(8'h7A, 3, 16'h007A, 1);
        by(8'hAA); by(8'h00); by(8'h55); by(8'h66);
        idle(2);
        chk("t3_broken_hdr", {busy_a, frame_count_a}, {1'b0, 8'd2});

        // Inter-byte timeout.
        by(8'hAA); by(8'h55); px(8'h01, 0, 16'h0001, 0);
        idle(99);
        chk("t4_busy_before_limit", {busy_a, err_count_a}, {1'b1, 8'd0});
        idle(1);
        chk("t4_after_timeout", {busy_a, err_count_a, wr_addr_a}, {1'b0, 8'd1, 8'd0});
        by(8'hAA); by(8'h55); px(8'h02, 0, 16'h0002, 0);
        px(8'h03, 1, 16'h0003, 0); px(8'h04, 2, 16'h0004, 0); px(8'h05, 3, 16'h0005, 1);
        idle(2);
        chk("t4_frame_count", frame_count_a, 3);

        // Framing error on the third pixel byte, then saturation.
        by(8'hAA); by(8'h55); px(8'h11, 0, 16'h0011, 0); px(8'h22, 1, 16'h0022, 0);
        fe(8'h33);
        idle(1);
        chk("t5_abort", {busy_a, err_count_a, wr_addr_a}, {1'b0, 8'd2, 8'd0});
        by(8'h55); by(8'h44);
        idle(1);
        chk("t5_needs_header", busy_a, 0);
        for (int i = 0; i < 260; i++) fe(8'hAA);
        idle(1);
        chk("t5_err_saturated", err_count_a, 255);
        chk("t5_frames_kept", frame_count_a, 3);

        // Reset mid-frame at address 2.
        by(8'hAA); by(8'h55); px(8'hA1, 0, 16'h00A1, 0); px(8'hA2, 1, 16'h00A2, 0);
        idle(1);
        chk("t6_mid_frame_addr", {busy_a, wr_addr_a}, {1'b1, 8'd2});
        rst = 1'b1;
        idle(1);
        chk_reset_state("t6_rst");
        rst = 1'b0;
        by(8'h55); by(8'h10); by(8'h20);
        idle(1);
        chk("t6_needs_aa", busy_a, 0);

        // Two frames back-to-back with no gap.
        by(8'hAA); by(8'h55);
        px(8'hC0, 0, 16'h00C0, 0); px(8'hC1, 1, 16'h00C1, 0);
        px(8'hC2, 2, 16'h00C2, 0); px(8'hC3, 3, 16'h00C3, 1);
        by(8'hAA); by(8'h55);
        px(8'hD0, 0, 16'h00D0, 0); px(8'hD1, 1, 16'h00D1, 0);
        px(8'hD2, 2, 16'h00D2, 0); px(8'hD3, 3, 16'h00D3, 1);
        idle(3);
        chk("t6_two_frames", frame_count_a, 2);
        chk("t6_err_after_rst", err_count_a, 0);

        chk("a_pending_writes", qa.size(), 0);
        chk("b_pending_writes", qb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
